// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and shared memory port of mem_port_arbiter, grouped as one bundle.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ready;
    logic        d_rvalid;
    logic [63:0] d_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one fixed-latency memory port (IDLE/ACCESS/RESPOND).
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention instead of fixed data priority.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state, state_nxt;
    logic        owner_d;
    logic        we_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic [3:0]  cnt;
    logic        grant_d;
    logic        grant_if;
    logic        accept;

    // Grants are only honoured in IDLE and never while reset is held, so ready stays 0 under reset.
    assign accept = (state == IDLE) && !reset && (bus.d_req || bus.if_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_d;

    always_comb begin
        grant_d  = bus.d_req;
        grant_if = bus.if_req;
        if (bus.d_req && bus.if_req) begin
            grant_d  = !last_grant_d;
            grant_if = last_grant_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_d <= 1'b0;
        end else if (accept) begin
            last_grant_d <= grant_d;
        end
    end
`else
    assign grant_d  = bus.d_req;
    assign grant_if = bus.if_req && !bus.d_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.if_ready  = 1'b0;
        bus.d_ready   = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    bus.if_ready = grant_if;
                    bus.d_ready  = grant_d;
                end
                if (accept) state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.mem_en    = 1'b1;
                // A store writes once; later ACCESS cycles only hold the address for the latency window.
                bus.mem_we    = we_q && (cnt == CNT_INIT);
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                if (cnt == 4'd0) state_nxt = RESPOND;
            end
            RESPOND: begin
                if (owner_d) begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = rdata_q;
                end else begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = rdata_q[31:0];
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_d <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else if (accept) begin
            owner_d <= grant_d;
            we_q    <= grant_d && bus.d_we;
            addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
            wdata_q <= grant_d ? bus.d_wdata : '0;
            cnt     <= CNT_INIT;
        end else if (state == ACCESS) begin
            if (cnt == 4'd0) begin
                rdata_q <= we_q ? '0 : bus.mem_rdata;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: latency-2 instance for the main scenarios, latency-1 for back-to-back.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy2, busy1;
    int   cyc = 0;
    int   nchecks = 0;
    int   nerrs = 0;
    int   en2 = 0;

    typedef struct {bit is_d; logic [63:0] data; int cyc;} exp_t;
    typedef struct {logic [63:0] addr; logic [63:0] data;} wr_t;
    exp_t q2[$];
    exp_t q1[$];
    wr_t  w2[$];
    wr_t  w1[$];

    mem_port_arbiter_if a2();
    mem_port_arbiter_if a1();

    mem_port_arbiter #(.MEM_LATENCY(2)) dut2 (.clk(clk), .reset(rst), .bus(a2.slave), .busy(busy2));
    mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset(rst), .bus(a1.slave), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        case (a)
            64'h2000: return 64'h0000_0000_8A40_0005;
            64'h2004: return 64'h0000_0000_0050_0593;
            default:  return 64'hDEAD_BEEF_0000_0000 | a;
        endcase
    endfunction

    assign a2.mem_rdata = mem_model(a2.mem_addr);
    assign a1.mem_rdata = mem_model(a1.mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor, latency-2 instance
    initial forever begin
        exp_t e;
        wr_t  w;
        @(negedge clk);
        if (!rst) begin
            if (a2.mem_en) en2++;
            if (a2.if_rvalid || a2.d_rvalid) begin
                chk("rvalid_exclusive_l2", 64'(a2.if_rvalid & a2.d_rvalid), 64'd0);
                chk("rvalid_expected_l2", 64'(q2.size() != 0), 64'd1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    chk("rvalid_port_l2", 64'(a2.d_rvalid), 64'(e.is_d));
                    chk("rvalid_cycle_l2", 64'(cyc), 64'(e.cyc));
                    chk("rdata_l2", e.is_d ? a2.d_rdata : {32'h0, a2.if_rdata}, e.data);
                end
            end
            if (a2.mem_we) begin
                chk("write_expected_l2", 64'(w2.size() != 0), 64'd1);
                if (w2.size() != 0) begin
                    w = w2.pop_front();
                    chk("write_addr_l2", a2.mem_addr, w.addr);
                    chk("write_data_l2", a2.mem_wdata, w.data);
                end
            end
            if (!a2.mem_en) chk("idle_bus_l2", a2.mem_addr | a2.mem_wdata | 64'(a2.mem_we), 64'd0);
            if (busy2) chk("ready_while_busy_l2", 64'(a2.if_ready | a2.d_ready), 64'd0);
        end
    end

    // Scoreboard monitor, latency-1 instance
    initial forever begin
        exp_t e;
        wr_t  w;
        @(negedge clk);
        if (!rst) begin
            if (a1.if_rvalid || a1.d_rvalid) begin
                chk("rvalid_expected_l1", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("rvalid_port_l1", 64'(a1.d_rvalid), 64'(e.is_d));
                    chk("rvalid_cycle_l1", 64'(cyc), 64'(e.cyc));
                    chk("rdata_l1", e.is_d ? a1.d_rdata : {32'h0, a1.if_rdata}, e.data);
                end
            end
            if (a1.mem_we) begin
                chk("write_expected_l1", 64'(w1.size() != 0), 64'd1);
                if (w1.size() != 0) begin
                    w = w1.pop_front();
                    chk("write_addr_l1", a1.mem_addr, w.addr);
                    chk("write_data_l1", a1.mem_wdata, w.data);
                end
            end
            if (!a1.mem_en) chk("idle_bus_l1", a1.mem_addr | a1.mem_wdata | 64'(a1.mem_we), 64'd0);
        end
    end

    // Issue one request on the latency-2 instance; called #1 after a posedge, returns #1 after acceptance.
    task automatic issue2(input bit is_d, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] expd, input bit expect_resp);
        bit got = 1'b0;
        if (is_d) begin
            a2.d_req = 1'b1; a2.d_we = we; a2.d_addr = addr; a2.d_wdata = wdata;
        end else begin
            a2.if_req = 1'b1; a2.if_addr = addr;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (is_d ? a2.d_ready : a2.if_ready) got = 1'b1;
        end
        chk("accept_l2", 64'(got), 64'd1);
        if (got && expect_resp) begin
            q2.push_back('{is_d, expd, cyc + 3});
            if (is_d && we) w2.push_back('{addr, wdata});
        end
        @(posedge clk); #1;
        a2.d_req = 1'b0; a2.d_we = 1'b0; a2.d_addr = '0; a2.d_wdata = '0;
        a2.if_req = 1'b0; a2.if_addr = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q2.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        chk("drain_responses", 64'(q2.size() + q1.size()), 64'd0);
        chk("drain_writes", 64'(w2.size() + w1.size()), 64'd0);
        q2.delete(); q1.delete(); w2.delete(); w1.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] order;
        int e0;
        int bad;
        bit got;
        a2.if_req = 1'b0; a2.if_addr = '0; a2.d_req = 1'b0; a2.d_we = 1'b0; a2.d_addr = '0; a2.d_wdata = '0;
        a1.if_req = 1'b0; a1.if_addr = '0; a1.d_req = 1'b0; a1.d_we = 1'b0; a1.d_addr = '0; a1.d_wdata = '0;

        // Reset state with requests pending: nothing may be granted or driven
        a2.if_req = 1'b1; a2.d_req = 1'b1; a2.if_addr = 64'h2000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_if_ready", 64'(a2.if_ready), 64'd0);
        chk("reset_d_ready", 64'(a2.d_ready), 64'd0);
        chk("reset_busy", 64'(busy2), 64'd0);
        chk("reset_mem_en", 64'(a2.mem_en), 64'd0);
        chk("reset_rvalids", 64'(a2.if_rvalid | a2.d_rvalid), 64'd0);
        chk("reset_rdata", a2.d_rdata | 64'(a2.if_rdata), 64'd0);
        a2.if_req = 1'b0; a2.d_req = 1'b0; a2.if_addr = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single fetch: 2 ACCESS cycles, word returned at T+3
        e0 = en2;
        issue2(1'b0, 1'b0, 64'h2000, 64'h0, 64'h0000_0000_8A40_0005, 1'b1);
        drain();
        chk("fetch_mem_en_cycles", 64'(en2 - e0), 64'd2);

        // Store, then loads through the data port
        issue2(1'b1, 1'b1, 64'h80, 64'h1122_3344_5566_7788, 64'h0, 1'b1);
        drain();
        issue2(1'b1, 1'b0, 64'h100, 64'h0, 64'hDEAD_BEEF_0000_0100, 1'b1);
        drain();
        issue2(1'b1, 1'b0, 64'h2004, 64'h0, 64'h0000_0000_0050_0593, 1'b1);
        drain();

        // Reset during ACCESS of a load aborts it
        issue2(1'b1, 1'b0, 64'h500, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_mem_en", 64'(a2.mem_en), 64'd0);
        chk("abort_mem_we", 64'(a2.mem_we), 64'd0);
        chk("abort_busy", 64'(busy2), 64'd0);
        chk("abort_d_rvalid", 64'(a2.d_rvalid), 64'd0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (a2.d_rvalid || a2.mem_en) bad++;
        end
        chk("abort_no_late_activity", 64'(bad), 64'd0);
        @(posedge clk); #1;
        issue2(1'b1, 1'b0, 64'h200, 64'h0, 64'hDEAD_BEEF_0000_0200, 1'b1);
        drain();

        // Fetch first so the last grant is fetch, then hold both requests for 3 grants
        issue2(1'b0, 1'b0, 64'h2000, 64'h0, 64'h0000_0000_8A40_0005, 1'b1);
        drain();
`ifdef ARB_ROUND_ROBIN_EN
        order = 3'b101;
`else
        order = 3'b111;
`endif
        a2.d_req = 1'b1; a2.d_we = 1'b0; a2.d_addr = 64'h300;
        a2.if_req = 1'b1; a2.if_addr = 64'h2004;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (a2.d_ready || a2.if_ready) got = 1'b1;
            end
            chk("contention_accept", 64'(got), 64'd1);
            if (got) begin
                chk($sformatf("contention_grant_%0d", k), 64'(a2.d_ready), 64'(order[k]));
                q2.push_back('{order[k], order[k] ? 64'hDEAD_BEEF_0000_0300 : 64'h0000_0000_0050_0593, cyc + 3});
            end
            @(posedge clk); #1;
        end
        a2.d_req = 1'b0; a2.d_addr = '0; a2.if_req = 1'b0; a2.if_addr = '0;
        drain();

        // Fetch request raised while busy and withdrawn during RESPOND leaves no trace
        issue2(1'b1, 1'b0, 64'h400, 64'h0, 64'hDEAD_BEEF_0000_0400, 1'b1);
        a2.if_req = 1'b1; a2.if_addr = 64'h2000;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (a2.d_rvalid) got = 1'b1;
        end
        chk("drop_respond_seen", 64'(got), 64'd1);
        a2.if_req = 1'b0; a2.if_addr = '0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (a2.if_ready || a2.mem_en || busy2) bad++;
        end
        chk("drop_no_access", 64'(bad), 64'd0);
        @(posedge clk); #1;
        drain();

        // Latency 1: back-to-back fetches, then a store
        a1.if_req = 1'b1; a1.if_addr = 64'h2000;
        for (int n = 0; n < 2; n++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (a1.if_ready) got = 1'b1;
            end
            chk("l1_fetch_accept", 64'(got), 64'd1);
            if (got) q1.push_back('{1'b0, n == 0 ? 64'h0000_0000_8A40_0005 : 64'h0000_0000_0050_0593, cyc + 2});
            @(posedge clk); #1;
            a1.if_addr = 64'h2004;
        end
        a1.if_req = 1'b0; a1.if_addr = '0;
        drain();
        a1.d_req = 1'b1; a1.d_we = 1'b1; a1.d_addr = 64'h40; a1.d_wdata = 64'hA5A5_0000_1234_5678;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a1.d_ready) got = 1'b1;
        end
        chk("l1_store_accept", 64'(got), 64'd1);
        if (got) begin
            q1.push_back('{1'b1, 64'h0, cyc + 2});
            w1.push_back('{64'h40, 64'hA5A5_0000_1234_5678});
        end
        @(posedge clk); #1;
        a1.d_req = 1'b0; a1.d_we = 1'b0; a1.d_addr = '0; a1.d_wdata = '0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning cycles from memory access start to mem_rdata valid (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports if_req in 1 (fetch request), if_addr in 64 (byte address), if_ready out 1 (request accepted), if_rvalid out 1 (response pulse), if_rdata out 32 (instruction word).
REQ-005 SHALL have ports d_req in 1 (data request), d_we in 1 (1=store, 0=load), d_addr in 64, d_wdata in 64, d_ready out 1, d_rvalid out 1, d_rdata out 64.
REQ-006 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 64, mem_wdata out 64, mem_rdata in 64 (single shared byte-addressed memory port).
REQ-007 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESPOND.
REQ-009 IDLE: if any request pending, assert the winner's ready for exactly that cycle, latch owner/addr/wdata/we, load counter with MEM_LATENCY-1, go to ACCESS; otherwise stay IDLE.
REQ-010 Arbitration (default): d_req has fixed priority over if_req; loser keeps request high and is retried in next IDLE.
REQ-011 ACCESS: mem_en=1 and mem_addr/mem_wdata driven from latched values every ACCESS cycle; mem_we=1 only in first ACCESS cycle and only for stores.
REQ-012 ACCESS: counter decrements each cycle; at counter==0 capture mem_rdata into response register and go to RESPOND.
REQ-013 RESPOND: assert owner's rvalid for exactly one cycle with captured data, then return to IDLE; non-owner rvalid stays 0.
REQ-014 if_rdata SHALL be bits [31:0] of captured data; d_rdata full 64 bits for loads; stores SHALL still pulse d_rvalid (write ack) with d_rdata=0.
REQ-015 Latency: request accepted in cycle T yields rvalid in cycle T+1+MEM_LATENCY; throughput one transaction per MEM_LATENCY+2 cycles.
REQ-016 Requesters SHALL hold req/addr/wdata stable until ready; dropping req before ready cancels it with no side effect.
REQ-017 Requests arriving while busy SHALL not be accepted and ready SHALL stay 0 outside IDLE.
REQ-018 MEM_LATENCY=1: ACCESS lasts one cycle with mem_we and capture in the same cycle.
REQ-019 All outputs not listed as active SHALL be 0 (mem_addr/mem_wdata 0 when mem_en=0).

Reset
REQ-020 Reset SHALL asynchronously force IDLE, counter 0, response register 0, latched fields 0, and all outputs 0.
REQ-021 Reset mid-transaction SHALL abort it: no rvalid emitted, mem_en/mem_we drop immediately, no further memory write.
REQ-022 After reset release first acceptance SHALL occur no earlier than first posedge with reset low.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN SHALL select arbitration policy.
REQ-024 With ARB_ROUND_ROBIN_EN defined: on simultaneous if_req and d_req, grant the requester not granted last; last_grant register resets to fetch (first contention goes to data); single requester always wins.
REQ-025 Without ARB_ROUND_ROBIN_EN: fixed data priority per REQ-010; no last_grant register.

Verification
REQ-026 MEM_LATENCY=2, if_req only, if_addr=0x2000, mem_rdata=0x00000000_8A400005 -> if_ready at T, mem_en T+1..T+2, if_rvalid at T+3, if_rdata=0x8A400005.
REQ-027 d_req store d_addr=0x80, d_wdata=0x1122334455667788 -> mem_we=1 one cycle with those values, d_rvalid at T+3, d_rdata=0.
REQ-028 if_req and d_req both held high for 3 transactions -> default: data,data,data while fetch starves; ARB_ROUND_ROBIN_EN: data,fetch,data.
REQ-029 Assert reset during ACCESS of a load -> mem_en low same cycle, no d_rvalid ever, busy=0; post-reset load completes normally.
REQ-030 MEM_LATENCY=1, back-to-back fetches at 0x2000, 0x2004 -> if_rvalid spaced 3 cycles apart, correct words.
REQ-031 Drop if_req one cycle before IDLE while busy -> no if_ready, no memory access, state stays IDLE.
